// File: rtl/sirv_tl_frag_ctrl.sv
// sirv_tl_frag_ctrl: TL-UL fragmenter; do_repeat feeds the repeater's repeat input; SIRV_TL_FRAG_ERR_MERGE_EN merges dropped-ack errors.
module sirv_tl_frag_ctrl #(
  parameter int MAX_SIZE = 2,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        do_repeat,
  input  logic        in_a_valid,
  output logic        in_a_ready,
  input  logic [2:0]  in_a_opcode,
  input  logic [2:0]  in_a_param,
  input  logic [2:0]  in_a_size,
  input  logic [1:0]  in_a_source,
  input  logic [29:0] in_a_address,
  input  logic [3:0]  in_a_mask,
  input  logic [31:0] in_a_data,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [2:0]  out_a_param,
  output logic [2:0]  out_a_size,
  output logic [1:0]  out_a_source,
  output logic [29:0] out_a_address,
  output logic [3:0]  out_a_mask,
  output logic [31:0] out_a_data,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [1:0]  out_d_param,
  input  logic [2:0]  out_d_size,
  input  logic [1:0]  out_d_source,
  input  logic [31:0] out_d_data,
  input  logic        out_d_error,
  output logic        in_d_valid,
  input  logic        in_d_ready,
  output logic [2:0]  in_d_opcode,
  output logic [1:0]  in_d_param,
  output logic [2:0]  in_d_size,
  output logic [1:0]  in_d_source,
  output logic [31:0] in_d_data,
  output logic        in_d_error
);
  function automatic logic [CNT_W-1:0] last_of(input logic [2:0] s);
    return (int'(s) > MAX_SIZE) ? CNT_W'((1 << (int'(s) - MAX_SIZE)) - 1) : '0;
  endfunction
  logic [CNT_W-1:0] a_cnt;
  logic [2:0]       orig_size [4];
  logic             is_get [4];
  logic [CNT_W-1:0] d_cnt [4];
  logic a_get, a_big, a_last, a_fire, d_last, d_fwd, d_fire;
  assign a_get = in_a_opcode == 3'd4;
  assign a_big = int'(in_a_size) > MAX_SIZE;
  assign a_last = a_cnt == last_of(in_a_size);
  assign a_fire = out_a_valid & out_a_ready;
  assign out_a_valid = in_a_valid;
  assign in_a_ready = out_a_ready;
  assign do_repeat = rst_n & in_a_valid & a_get & !a_last;
  assign out_a_opcode = in_a_opcode;
  assign out_a_param = in_a_param;
  assign out_a_size = a_big ? 3'(MAX_SIZE) : in_a_size;
  assign out_a_source = in_a_source;
  assign out_a_address = in_a_address | (30'(a_cnt) << MAX_SIZE);
  assign out_a_mask = (a_get & a_big) ? 4'hF : in_a_mask;
  assign out_a_data = in_a_data;
  // Put acks before the last one are swallowed; Gets and final acks go through
  assign d_last = d_cnt[out_d_source] == last_of(orig_size[out_d_source]);
  assign d_fwd = is_get[out_d_source] | d_last;
  assign d_fire = out_d_valid & out_d_ready;
  assign in_d_valid = rst_n & out_d_valid & d_fwd;
  assign out_d_ready = d_fwd ? in_d_ready : 1'b1;
  assign in_d_opcode = out_d_opcode;
  assign in_d_param = out_d_param;
  assign in_d_size = orig_size[out_d_source];
  assign in_d_source = out_d_source;
  assign in_d_data = out_d_data;
`ifdef SIRV_TL_FRAG_ERR_MERGE_EN
  logic err_acc [4];
  assign in_d_error = out_d_error | err_acc[out_d_source];
`else
  assign in_d_error = out_d_error;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        orig_size[i] <= '0;
        is_get[i] <= 1'b0;
        d_cnt[i] <= '0;
`ifdef SIRV_TL_FRAG_ERR_MERGE_EN
        err_acc[i] <= 1'b0;
`endif
      end
    end else begin
      if (a_fire) a_cnt <= a_last ? '0 : a_cnt + 1'b1;
      if (a_fire && a_cnt == '0) begin
        orig_size[in_a_source] <= in_a_size;
        is_get[in_a_source] <= a_get;
        d_cnt[in_a_source] <= '0;
`ifdef SIRV_TL_FRAG_ERR_MERGE_EN
        err_acc[in_a_source] <= 1'b0;
`endif
      end
      if (d_fire) begin
        d_cnt[out_d_source] <= d_last ? '0 : d_cnt[out_d_source] + 1'b1;
`ifdef SIRV_TL_FRAG_ERR_MERGE_EN
        err_acc[out_d_source] <= !d_last & (err_acc[out_d_source] | out_d_error);
`endif
      end
    end
  end
endmodule

// File: tb/tb_sirv_tl_frag_ctrl.sv
// tb_sirv_tl_frag_ctrl: directed table, hand sequences and randomized transactions against a burst-level model.
module tb_sirv_tl_frag_ctrl;
`ifdef SIRV_TL_FRAG_ERR_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic do_repeat;
  logic in_a_valid, in_a_ready;
  logic [2:0] in_a_opcode, in_a_param, in_a_size;
  logic [1:0] in_a_source;
  logic [29:0] in_a_address;
  logic [3:0] in_a_mask;
  logic [31:0] in_a_data;
  logic out_a_valid, out_a_ready;
  logic [2:0] out_a_opcode, out_a_param, out_a_size;
  logic [1:0] out_a_source;
  logic [29:0] out_a_address;
  logic [3:0] out_a_mask;
  logic [31:0] out_a_data;
  logic out_d_valid, out_d_ready;
  logic [2:0] out_d_opcode, out_d_size;
  logic [1:0] out_d_param, out_d_source;
  logic [31:0] out_d_data;
  logic out_d_error;
  logic in_d_valid, in_d_ready;
  logic [2:0] in_d_opcode, in_d_size;
  logic [1:0] in_d_param, in_d_source;
  logic [31:0] in_d_data;
  logic in_d_error;
  int checks = 0, errors = 0, a_fires = 0;

  sirv_tl_frag_ctrl dut (
    .clk(clk), .rst_n(rst_n), .do_repeat(do_repeat),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_data(out_d_data), .out_d_error(out_d_error),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_data(in_d_data), .in_d_error(in_d_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (out_a_valid && out_a_ready) a_fires++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] opc, input logic [2:0] sz, input logic [1:0] src,
                       input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] data);
    in_a_valid = 1'b1; in_a_opcode = opc; in_a_param = 3'($urandom_range(0, 7)); in_a_size = sz;
    in_a_source = src; in_a_address = addr; in_a_mask = mask; in_a_data = data;
  endtask

  task automatic a_frag(input string nm, input logic [29:0] ea, input logic [2:0] es,
                        input logic [3:0] em, input logic er, input int stall);
    out_a_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk({nm, "_stall_addr"}, 32'(out_a_address), 32'(ea));
      chk({nm, "_stall_rep"}, 32'(do_repeat), 32'(er));
      @(posedge clk); #1;
    end
    out_a_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_addr"}, 32'(out_a_address), 32'(ea));
    chk({nm, "_size"}, 32'(out_a_size), 32'(es));
    chk({nm, "_mask"}, 32'(out_a_mask), 32'(em));
    chk({nm, "_rep"}, 32'(do_repeat), 32'(er));
    chk({nm, "_vld"}, 32'({out_a_valid, in_a_ready}), 32'h3);
    chk({nm, "_pass"}, {out_a_data[23:0], 2'(out_a_source), 3'(out_a_param), 3'(out_a_opcode)},
        {in_a_data[23:0], 2'(in_a_source), 3'(in_a_param), 3'(in_a_opcode)});
    @(posedge clk); #1;
    out_a_ready = 1'b0;
  endtask

  task automatic d_beat(input string nm, input logic [1:0] src, input logic [2:0] opc,
                        input logic err, input logic efwd, input logic [2:0] es,
                        input logic eerr, input logic stall);
    logic [31:0] dat;
    dat = $urandom;
    out_d_valid = 1'b1; out_d_source = src; out_d_opcode = opc; out_d_error = err;
    out_d_data = dat; out_d_size = 3'd2; out_d_param = 2'd0;
    if (stall && efwd) begin
      in_d_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_stall_rdy"}, 32'(out_d_ready), 32'h0);
      @(posedge clk); #1;
    end
    in_d_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_vld"}, 32'(in_d_valid), 32'(efwd));
    chk({nm, "_rdy"}, 32'(out_d_ready), 32'h1);
    if (efwd) begin
      chk({nm, "_size"}, 32'(in_d_size), 32'(es));
      chk({nm, "_err"}, 32'(in_d_error), 32'(eerr));
      chk({nm, "_data"}, in_d_data, dat);
      chk({nm, "_src"}, 32'(in_d_source), 32'(src));
    end
    @(posedge clk); #1;
    out_d_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0] opc, sz;
    logic [29:0] addr;
    logic [3:0] mask;
    logic [2:0] esz;
    logic [3:0] emask;
    logic erep;
  } vec_t;
  vec_t vt[8];

  int rem[4], nfr[4];
  bit rget[4], racc[4];
  logic [2:0] rsz[4], ropc[4];
  logic [29:0] raddr[4];
  logic [3:0] rmask[4];

  initial begin
    vt[0] = '{3'd4, 3'd2, 30'h100, 4'hF, 3'd2, 4'hF, 1'b0};
    vt[1] = '{3'd4, 3'd4, 30'h040, 4'h1, 3'd2, 4'hF, 1'b1};
    vt[2] = '{3'd4, 3'd1, 30'h002, 4'hC, 3'd1, 4'hC, 1'b0};
    vt[3] = '{3'd4, 3'd0, 30'h003, 4'h8, 3'd0, 4'h8, 1'b0};
    vt[4] = '{3'd0, 3'd3, 30'h080, 4'hF, 3'd2, 4'hF, 1'b0};
    vt[5] = '{3'd1, 3'd2, 30'h010, 4'h5, 3'd2, 4'h5, 1'b0};
    vt[6] = '{3'd4, 3'd7, 30'h000, 4'h1, 3'd2, 4'hF, 1'b1};
    vt[7] = '{3'd0, 3'd5, 30'h020, 4'h3, 3'd2, 4'h3, 1'b0};
    rst_n = 1'b0; in_a_valid = 1'b0; out_a_ready = 1'b0; out_d_valid = 1'b0; in_d_ready = 1'b1;
    in_a_opcode = 0; in_a_param = 0; in_a_size = 0; in_a_source = 0; in_a_address = 0;
    in_a_mask = 0; in_a_data = 0; out_d_opcode = 0; out_d_param = 0; out_d_size = 0;
    out_d_source = 0; out_d_data = 0; out_d_error = 0;
    // reset: outputs quiet even with live inputs
    set_a(3'd4, 3'd4, 2'd0, 30'h40, 4'hF, 32'h0);
    out_d_valid = 1'b1;
    #2;
    chk("rst_repeat", 32'(do_repeat), 32'h0);
    chk("rst_in_d_valid", 32'(in_d_valid), 32'h0);
    chk("rst_out_a_valid", 32'(out_a_valid), 32'h1);
    in_a_valid = 1'b0; out_d_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    // combinational fragment fields at a_cnt=0, no fire
    for (int i = 0; i < 8; i++) begin
      set_a(vt[i].opc, vt[i].sz, 2'd1, vt[i].addr, vt[i].mask, 32'h0);
      out_a_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_size", i), 32'(out_a_size), 32'(vt[i].esz));
      chk($sformatf("vec%0d_mask", i), 32'(out_a_mask), 32'(vt[i].emask));
      chk($sformatf("vec%0d_rep", i), 32'(do_repeat), 32'(vt[i].erep));
      chk($sformatf("vec%0d_addr", i), 32'(out_a_address), 32'(vt[i].addr));
      chk($sformatf("vec%0d_rdy", i), 32'(in_a_ready), 32'h0);
      @(posedge clk); #1;
    end
    in_a_valid = 1'b0;
    // Get size 2: single fragment
    set_a(3'd4, 3'd2, 2'd0, 30'h100, 4'hF, 32'h0);
    a_frag("g2", 30'h100, 3'd2, 4'hF, 1'b0, 0);
    in_a_valid = 1'b0;
    d_beat("g2d", 2'd0, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    // Get size 4: four fragments
    set_a(3'd4, 3'd4, 2'd0, 30'h40, 4'h1, 32'h0);
    for (int k = 0; k < 4; k++) a_frag($sformatf("g4_%0d", k), 30'h40 + 30'(4 * k), 3'd2, 4'hF, k < 3, 0);
    in_a_valid = 1'b0;
    for (int k = 0; k < 4; k++) d_beat($sformatf("g4d_%0d", k), 2'd0, 3'd1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    // PutFull size 3: two beats, first ack dropped
    set_a(3'd0, 3'd3, 2'd0, 30'h80, 4'hF, 32'hAAAA_0001);
    a_frag("p3_0", 30'h80, 3'd2, 4'hF, 1'b0, 0);
    in_a_data = 32'hAAAA_0002;
    a_frag("p3_1", 30'h84, 3'd2, 4'hF, 1'b0, 0);
    in_a_valid = 1'b0;
    d_beat("p3d_0", 2'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    d_beat("p3d_1", 2'd0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    // Get size 3 with a stall between fragments
    a_fires = 0;
    set_a(3'd4, 3'd3, 2'd0, 30'h200, 4'hF, 32'h0);
    a_frag("st_0", 30'h200, 3'd2, 4'hF, 1'b1, 0);
    a_frag("st_1", 30'h204, 3'd2, 4'hF, 1'b0, 1);
    in_a_valid = 1'b0;
    chk("st_fires", 32'(a_fires), 32'd2);
    d_beat("st_d0", 2'd0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    d_beat("st_d1", 2'd0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    set_a(3'd4, 3'd2, 2'd0, 30'h300, 4'h3, 32'h0);
    a_frag("st_after", 30'h300, 3'd2, 4'h3, 1'b0, 0);
    in_a_valid = 1'b0;
    d_beat("st_after_d", 2'd0, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    // interleaved sources
    set_a(3'd4, 3'd3, 2'd0, 30'h0, 4'hF, 32'h0);
    a_frag("il_g0", 30'h0, 3'd2, 4'hF, 1'b1, 0);
    a_frag("il_g1", 30'h4, 3'd2, 4'hF, 1'b0, 0);
    set_a(3'd0, 3'd3, 2'd1, 30'h20, 4'hF, 32'h1);
    a_frag("il_p0", 30'h20, 3'd2, 4'hF, 1'b0, 0);
    a_frag("il_p1", 30'h24, 3'd2, 4'hF, 1'b0, 0);
    in_a_valid = 1'b0;
    d_beat("il_d0", 2'd0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    d_beat("il_d1", 2'd1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    d_beat("il_d2", 2'd0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    d_beat("il_d3", 2'd1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    // error on the dropped ack
    set_a(3'd0, 3'd3, 2'd2, 30'h400, 4'hF, 32'h5);
    a_frag("er_0", 30'h400, 3'd2, 4'hF, 1'b0, 0);
    a_frag("er_1", 30'h404, 3'd2, 4'hF, 1'b0, 0);
    in_a_valid = 1'b0;
    d_beat("er_d0", 2'd2, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
    d_beat("er_d1", 2'd2, 3'd0, 1'b0, 1'b1, 3'd3, MERGE, 1'b0);
    // reset mid-burst restarts the fragment counter
    set_a(3'd4, 3'd4, 2'd3, 30'h500, 4'hF, 32'h0);
    a_frag("mr_0", 30'h500, 3'd2, 4'hF, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_addr", 32'(out_a_address), 32'h500);
    chk("mr_rep", 32'(do_repeat), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1; in_a_valid = 1'b0;
    @(posedge clk); #1;
    // randomized bursts checked against a burst-level model
    for (int r = 0; r < 40; r++) begin
      int k;
      k = $urandom_range(1, 4);
      for (int s = 0; s < k; s++) begin
        int sel;
        sel = $urandom_range(0, 2);
        ropc[s] = (sel == 0) ? 3'd4 : (sel == 1) ? 3'd0 : 3'd1;
        rsz[s] = 3'($urandom_range(0, 4));
        raddr[s] = {24'($urandom), 6'b0};
        rmask[s] = 4'($urandom);
        rget[s] = ropc[s] == 3'd4;
        nfr[s] = (rsz[s] > 2) ? (1 << (rsz[s] - 2)) : 1;
        rem[s] = nfr[s];
        racc[s] = 1'b0;
        for (int f = 0; f < nfr[s]; f++) begin
          set_a(ropc[s], rsz[s], 2'(s), raddr[s], rmask[s], $urandom);
          a_frag($sformatf("rnd%0d_s%0d_f%0d", r, s, f), raddr[s] + 30'(4 * f),
                 (rsz[s] > 2) ? 3'd2 : rsz[s], (rget[s] && rsz[s] > 2) ? 4'hF : rmask[s],
                 rget[s] && f < nfr[s] - 1, $urandom_range(0, 2));
        end
        in_a_valid = 1'b0;
      end
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
        int s;
        logic e, fwd;
        s = $urandom_range(0, k - 1);
        if (rem[s] > 0) begin
          e = 1'($urandom_range(0, 3) == 0);
          racc[s] = racc[s] | e;
          fwd = rget[s] || rem[s] == 1;
          d_beat($sformatf("rnd%0d_d_s%0d_%0d", r, s, rem[s]), 2'(s), rget[s] ? 3'd1 : 3'd0, e,
                 fwd, rsz[s], MERGE ? racc[s] : e, 1'($urandom_range(0, 3) == 0));
          rem[s]--;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sirv_tl_frag_ctrl.md
Name: sirv_tl_frag_ctrl

Overview:
- TL-UL fragmentation controller placed between an A-channel repeater (enq side faces the wide master) and a narrow slave port.
- Splits any request whose size exceeds MAX_SIZE into 2^(size-MAX_SIZE) fragments of size MAX_SIZE.
- Drives the repeater's repeat input so each Get is replayed until its last fragment issues.
- Reshapes D-channel responses so the master sees the protocol-correct response for its original size.

Parameters:
MAX_SIZE, 2, log2 of the largest fragment in bytes the slave accepts (beat = 4 bytes)
CNT_W, 5, fragment counter width; must be at least 7-MAX_SIZE

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
repeat  output  1  to repeater: hold the current A request for another fragment
in_a_valid  input  1  A request from repeater deq
in_a_ready  output  1  A ready to repeater deq
in_a_opcode  input  3  A opcode (0 PutFull, 1 PutPartial, 4 Get)
in_a_param  input  3  A param
in_a_size  input  3  original log2 bytes
in_a_source  input  2  source id
in_a_address  input  30  original address, aligned to in_a_size
in_a_mask  input  4  byte mask
in_a_data  input  32  write data
out_a_valid / out_a_ready  output / input  1 / 1  fragment to slave
out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data  output  3,3,3,2,30,4,32  fragment fields
out_d_valid / out_d_ready  input / output  1 / 1  slave response
out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_data, out_d_error  input  3,2,3,2,32,1  slave response fields
in_d_valid / in_d_ready  output / input  1 / 1  response to master
in_d_opcode, in_d_param, in_d_size, in_d_source, in_d_data, in_d_error  output  3,2,3,2,32,1  response fields

Behaviour:
- Reset: a_cnt=0; all per-source table entries cleared (orig_size=0, is_get=0, d_cnt=0, err_acc=0). Outputs during reset: repeat=0, in_d_valid=0. out_a_valid follows in_a_valid combinationally.
- A path is zero-latency combinational: out_a_valid=in_a_valid; in_a_ready=out_a_ready; a_fire=out_a_valid&out_a_ready.
- last_idx = (in_a_size>MAX_SIZE) ? 2^(in_a_size-MAX_SIZE)-1 : 0.
- a_last = (a_cnt==last_idx).
- repeat = in_a_valid & (in_a_opcode==4) & !a_last. Put beats are already separate enq beats, so repeat=0 for Puts.
- Fragment fields:
  - out_a_size = min(in_a_size, MAX_SIZE).
  - out_a_address = in_a_address | (a_cnt << MAX_SIZE).
  - out_a_mask = 4'hF for a Get with in_a_size>MAX_SIZE; otherwise in_a_mask.
  - Other fields pass through.
- a_cnt: on a_fire, cleared to 0 if a_last, else incremented. Size<=MAX_SIZE is a single fragment with a_cnt held at 0.
- On a_fire with a_cnt==0: table[in_a_source] <= {orig_size=in_a_size, is_get=(opcode==4), d_cnt=0, err_acc=0}.
- D path: e=table[out_d_source]; d_last = (e.d_cnt == last_idx computed from e.orig_size).
  - Get, or any response with orig_size<=MAX_SIZE: forwarded. in_d_valid=out_d_valid, out_d_ready=in_d_ready, in_d_size=e.orig_size, other fields pass through.
  - Put fragment with !d_last: dropped. in_d_valid=0, out_d_ready=1; d_cnt increments on out_d fire.
  - Put with d_last: forwarded with in_d_size=e.orig_size.
  - On a forwarded fire with d_last, d_cnt clears to 0. On a forwarded fire without d_last (Get), d_cnt increments.
- Same-cycle A first-fire and D fire on the same source is illegal (TL source reuse rule); the implementation need not handle it. Different sources are fully independent.
- rst_n asserted mid-burst: counters and table abort immediately. Partial responses after reset are not the block's responsibility.

Optional Feature:
- Macro: SIRV_TL_FRAG_ERR_MERGE_EN.
- Defined: err_acc ORs out_d_error of every dropped Put ack for that source. The final forwarded ack carries in_d_error = out_d_error | err_acc. For Gets, in_d_error is sticky across the remaining beats of that burst.
- Undefined: err_acc is absent and in_d_error = out_d_error unmodified.

Test Plan:
- Get size=2, addr 0x100, out_a_ready=1 -> one fragment at 0x100 size 2; repeat=0; one D beat forwarded with size 2.
- Get size=4, addr 0x40 -> four fragments at 0x40, 0x44, 0x48, 0x4C, each size 2, mask F. repeat=1 on the first three, 0 on the fourth. Four D beats forwarded, each with in_d_size=4.
- PutFull size=3, addr 0x80, two enq beats -> fragments at 0x80 and 0x84. First AccessAck dropped (in_d_valid=0, out_d_ready=1). Second forwarded with size 3.
- Get size=3 with out_a_ready toggling 1,0,1 -> address and repeat held during the stall; a_cnt advances only on fire; exactly two fragments issued.
- Interleaved sources 0 (Get size 3) and 1 (Put size 3), D responses alternating -> each source's d_cnt tracks independently; correct sizes forwarded; source 1 first ack dropped.
- SIRV_TL_FRAG_ERR_MERGE_EN defined, Put size 3, first ack error=1, second error=0 -> forwarded ack error=1. With the macro undefined -> forwarded ack error=0.
